regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised integer register file for the pipelined core.
- Provides two combinational read ports, one synchronous write port, optional write-to-read bypass, and a per-register scoreboard of pending writes.
- Sits between decode (reads and issue) and writeback (writes).
- The scoreboard lets decode stall on RAW hazards and detect WAW issue conflicts without extra pipeline logic.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers; power of two, 2..64. Derived localparam AW = $clog2(NREG) sets the address width.
- BYPASS, 1, 1 = write data forwarded to same-cycle reads; 0 = reads return stored value only.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data.
- rs2_data  out  XLEN  read port 2 data.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback register index.
- wr_data  in  XLEN  writeback data.
- iss_valid  in  1  instruction issued this cycle with destination iss_rd.
- iss_rd  in  AW  destination register of the issued instruction.
- rs1_busy  out  1  rs1_addr has an outstanding write not satisfiable this cycle.
- rs2_busy  out  1  same, for rs2_addr.
- iss_conflict  out  1  iss_valid targets a register already pending (WAW).
- pend_cnt  out  AW+1  number of registers currently pending.

Behaviour:
Interface:
- One clock (clk); reset is synchronous and active-high (rst).

Reset:
- On a clk edge with rst=1, all NREG registers clear to 0.
- All pending bits clear; pend_cnt is 0.
- rst has priority over wr_en and iss_valid in the same cycle.
- While rst is asserted, outputs reflect the cleared state from the next cycle on.
- Reset mid-operation discards all outstanding pending state; later writebacks for pre-reset issues are ordinary writes.

Register 0:
- Hardwired zero: reads return 0, writes are ignored.
- Never pending: issue to x0 neither sets a bit nor raises iss_conflict.

Write:
- wr_en=1 and wr_addr!=0: regs[wr_addr] <= wr_data at clk edge.
- One-cycle write latency to storage.

Read:
- Purely combinational, zero latency.
- BYPASS=1: if wr_en=1, wr_addr!=0 and wr_addr==rsN_addr, then rsN_data = wr_data (write-first). Otherwise rsN_data = regs[rsN_addr].
- BYPASS=0: rsN_data = regs[rsN_addr] (old value during a same-cycle write).

Scoreboard:
- One pending bit per register 1..NREG-1.
- Set at edge when iss_valid=1 and iss_rd!=0.
- Cleared at edge when wr_en=1 and wr_addr!=0, unless the same-cycle issue targets the same register; issue wins and the bit stays set (new producer).
- Writeback to a non-pending register: data is written, pending unchanged, no error.

Busy outputs:
- BYPASS=1: rsN_busy = pending[rsN_addr] & ~(wr_en & wr_addr==rsN_addr).
- BYPASS=0: rsN_busy = pending[rsN_addr].
- Address 0 is never busy.

iss_conflict:
- Combinational: iss_valid & iss_rd!=0 & pending[iss_rd] & ~(wr_en & wr_addr==iss_rd).
- Informational only; the issue still sets the bit.

pend_cnt:
- Registered population count of pending bits, updated the same edge as the bits.
- Maximum value NREG-1; no wrap possible.

Test Plan:
- Reset then read all registers -> every rs1_data/rs2_data = 0; busy=0; pend_cnt=0.
- Write x5=0xDEADBEEF, same cycle rs1_addr=5 -> BYPASS=1: rs1_data=0xDEADBEEF immediately; BYPASS=0: old 0, then 0xDEADBEEF next cycle.
- Write x0=0x1234 and issue to x0 -> reading x0 returns 0; rs1_busy=0; pend_cnt unchanged; iss_conflict=0.
- Issue x7; next cycle rs2_addr=7 -> rs2_busy=1, pend_cnt=1. Writeback x7=0x55 -> same cycle rs2_busy=0, rs2_data=0x55 (BYPASS=1). Next cycle pend_cnt=0.
- Pending x3, same cycle writeback x3 and issue x3 -> iss_conflict=0; x3 stays pending; pend_cnt stays 1. Issue x3 again without writeback -> iss_conflict=1.
- Issue x1..x31 on consecutive cycles, then assert rst with wr_en=1 -> pend_cnt reaches 31; after reset edge, pend_cnt=0 and all registers read 0 (write suppressed).

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with two combinational read ports, one
// synchronous write port, optional write-to-read bypass, and a per-register
// scoreboard of pending writes used by decode for RAW stalls and WAW detection.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            iss_conflict,
    output logic [AW:0]     pend_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pend_next;

    logic wr_live;
    logic iss_live;
    logic rs1_fwd;
    logic rs2_fwd;

    // Counts set bits; sized so a full scoreboard (NREG-1 bits) always fits.
    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign wr_live  = wr_en && (wr_addr != '0);
    assign iss_live = iss_valid && (iss_rd != '0);

    // Storage update; x0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Next scoreboard state: writeback retires, a same-cycle issue to the same register re-arms it.
    always_comb begin
        pend_next = pending;
        if (wr_live) begin
            pend_next[wr_addr] = 1'b0;
        end
        if (iss_live) begin
            pend_next[iss_rd] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    // Scoreboard bits and their population count move together on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pend_next;
            pend_cnt <= popcount(pend_next);
        end
    end

    // Read ports: x0 forced to zero, write-first forwarding when bypass is enabled.
    always_comb begin
        rs1_fwd = (BYPASS != 0) && wr_live && (wr_addr == rs1_addr);
        rs2_fwd = (BYPASS != 0) && wr_live && (wr_addr == rs2_addr);

        rs1_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = rs1_fwd ? wr_data : regs[rs1_addr];
        end

        rs2_data = '0;
        if (rs2_addr != '0) begin
            rs2_data = rs2_fwd ? wr_data : regs[rs2_addr];
        end
    end

    // Hazard flags; a writeback landing this cycle satisfies a reader only when it can be forwarded.
    always_comb begin
        rs1_busy     = pending[rs1_addr] && !rs1_fwd;
        rs2_busy     = pending[rs2_addr] && !rs2_fwd;
        iss_conflict = iss_live && pending[iss_rd]
                       && !(wr_en && (wr_addr == iss_rd));
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed table-driven bench for regfile_sb, with a second
// instance built without bypass sharing the same stimulus.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            rst;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;

    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            rs1_busy, rs2_busy, iss_conflict;
    logic [AW:0]     pend_cnt;

    logic [XLEN-1:0] nb_rs1_data, nb_rs2_data;
    logic            nb_rs1_busy, nb_rs2_busy, nb_iss_conflict;
    logic [AW:0]     nb_pend_cnt;

    int checks;
    int failures;

    typedef struct {
        logic            wr_en;
        logic [AW-1:0]   wr_addr;
        logic [XLEN-1:0] wr_data;
        logic            iss_valid;
        logic [AW-1:0]   iss_rd;
        logic [AW-1:0]   rs1_addr;
        logic [AW-1:0]   rs2_addr;
        logic [XLEN-1:0] e_rs1;
        logic [XLEN-1:0] e_rs2;
        logic            e_b1;
        logic            e_b2;
        logic            e_conf;
        logic [AW:0]     e_cnt;
        logic [XLEN-1:0] e_nb_rs1;
        logic            e_nb_b1;
    } vec_t;

    vec_t vecs [18];

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .iss_conflict(iss_conflict), .pend_cnt(pend_cnt)
    );

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rs1_busy(nb_rs1_busy), .rs2_busy(nb_rs2_busy),
        .iss_conflict(nb_iss_conflict), .pend_cnt(nb_pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic we, input logic [AW-1:0] wa,
                                 input logic [XLEN-1:0] wd, input logic iv,
                                 input logic [AW-1:0] ir, input logic [AW-1:0] a1,
                                 input logic [AW-1:0] a2);
        rst       = r;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        iss_valid = iv;
        iss_rd    = ir;
        rs1_addr  = a1;
        rs2_addr  = a2;
    endtask

    // Inputs change 1 ns after a rising edge; outputs are sampled at the falling edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd31, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd6,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0, 6'd0, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 5'd0, 32'h1234,     1'b1, 5'd0, 5'd0, 5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd0, 5'd7,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd7,  32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 1'b0, 6'd1, 32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b1, 5'd7, 32'h55,       1'b0, 5'd0, 5'd7, 5'd7,  32'h55,       32'h55,       1'b0, 1'b0, 1'b0, 6'd1, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7,  32'h55,       32'h55,       1'b0, 1'b0, 1'b0, 6'd0, 32'h55,       1'b0};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd3, 5'd3, 5'd3,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 6'd1, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd0,  32'hA5A5A5A5, 32'h0,        1'b1, 1'b0, 1'b1, 6'd1, 32'hA5A5A5A5, 1'b1};
        vecs[12] = '{1'b1, 5'd9, 32'h99,       1'b1, 5'd9, 5'd9, 5'd0,  32'h99,       32'h0,        1'b0, 1'b0, 1'b0, 6'd1, 32'h0,        1'b0};
        vecs[13] = '{1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 5'd3, 5'd9,  32'hA5A5A5A5, 32'h99,       1'b1, 1'b1, 1'b0, 6'd2, 32'hA5A5A5A5, 1'b1};
        vecs[14] = '{1'b1, 5'd3, 32'h33333333, 1'b1, 5'd9, 5'd4, 5'd9,  32'h44,       32'h99,       1'b0, 1'b1, 1'b1, 6'd2, 32'h44,       1'b0};
        vecs[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd9,  32'h33333333, 32'h99,       1'b0, 1'b1, 1'b0, 6'd1, 32'h33333333, 1'b0};
        vecs[16] = '{1'b1, 5'd9, 32'h11112222, 1'b0, 5'd0, 5'd9, 5'd9,  32'h11112222, 32'h11112222, 1'b0, 1'b0, 1'b0, 6'd1, 32'h99,       1'b1};
        vecs[17] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd3,  32'h11112222, 32'h33333333, 1'b0, 1'b0, 1'b0, 6'd0, 32'h11112222, 1'b0};

        $display("[TB] start");
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        #2;
        stepCycle();
        stepCycle();

        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b0, vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data,
                          vecs[i].iss_valid, vecs[i].iss_rd,
                          vecs[i].rs1_addr, vecs[i].rs2_addr);
            @(negedge clk);
            checkOutput($sformatf("v%0d rs1_data", i), rs1_data, vecs[i].e_rs1);
            checkOutput($sformatf("v%0d rs2_data", i), rs2_data, vecs[i].e_rs2);
            checkOutput($sformatf("v%0d rs1_busy", i), 32'(rs1_busy), 32'(vecs[i].e_b1));
            checkOutput($sformatf("v%0d rs2_busy", i), 32'(rs2_busy), 32'(vecs[i].e_b2));
            checkOutput($sformatf("v%0d iss_conflict", i), 32'(iss_conflict), 32'(vecs[i].e_conf));
            checkOutput($sformatf("v%0d pend_cnt", i), 32'(pend_cnt), 32'(vecs[i].e_cnt));
            checkOutput($sformatf("v%0d nobyp rs1_data", i), nb_rs1_data, vecs[i].e_nb_rs1);
            checkOutput($sformatf("v%0d nobyp rs1_busy", i), 32'(nb_rs1_busy), 32'(vecs[i].e_nb_b1));
            stepCycle();
        end

        // Fill the scoreboard one register per cycle.
        for (int r = 1; r < NREG; r++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(r), '0, '0);
            @(negedge clk);
            checkOutput($sformatf("fill%0d pend_cnt", r), 32'(pend_cnt), 32'(r - 1));
            checkOutput($sformatf("fill%0d iss_conflict", r), 32'(iss_conflict), 32'd0);
            stepCycle();
        end

        // Reset with a concurrent write and issue; reset must win.
        applyStimulus(1'b1, 1'b1, 5'd5, 32'hFFFFFFFF, 1'b1, 5'd2, 5'd2, 5'd31);
        @(negedge clk);
        checkOutput("full pend_cnt", 32'(pend_cnt), 32'd31);
        checkOutput("full iss_conflict", 32'(iss_conflict), 32'd1);
        checkOutput("full rs1_busy", 32'(rs1_busy), 32'd1);
        stepCycle();

        for (int r = 0; r < NREG; r++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, AW'(r), AW'(NREG - 1 - r));
            @(negedge clk);
            checkOutput($sformatf("post-rst x%0d rs1_data", r), rs1_data, 32'h0);
            checkOutput($sformatf("post-rst x%0d rs2_data", r), rs2_data, 32'h0);
            checkOutput($sformatf("post-rst x%0d rs1_busy", r), 32'(rs1_busy), 32'd0);
            checkOutput($sformatf("post-rst x%0d nobyp rs1_data", r), nb_rs1_data, 32'h0);
            checkOutput($sformatf("post-rst x%0d pend_cnt", r), 32'(pend_cnt), 32'd0);
            stepCycle();
        end

        // Writeback for an issue made before reset is an ordinary write.
        applyStimulus(1'b0, 1'b1, 5'd4, 32'h4444, 1'b0, '0, 5'd4, 5'd0);
        @(negedge clk);
        checkOutput("late wb rs1_busy", 32'(rs1_busy), 32'd0);
        checkOutput("late wb nobyp rs1_data", nb_rs1_data, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd4, 5'd0);
        @(negedge clk);
        checkOutput("late wb rs1_data", rs1_data, 32'h4444);
        checkOutput("late wb pend_cnt", 32'(pend_cnt), 32'd0);
        checkOutput("late wb nobyp pend_cnt", 32'(nb_pend_cnt), 32'd0);
        stepCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
